param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the toy-TPU 32b x 8 buffer used between the loaders and the PE array.
//  Width and power-of-2 depth are parameters, and all DEPTH entries are usable.
//  Adds an occupancy count, programmable almost-full/almost-empty flags, and a full+read pass-through.
//  Adds synchronous flush, plus sticky overflow/underflow error flags for debug.
// PARAMETERS
//  DATA_W    32  data word width in bits
//  DEPTH     8   number of entries; power of 2, >= 2
//  AF_LEVEL  6   o_afull asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  1   o_aempty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  CW = $clog2(DEPTH)+1 (localparam, count width)
// PORTS
//  i_clk      in   1       clock; one clock domain, all logic on posedge
//  i_rst      in   1       reset; synchronous, active-high
//  i_flush    in   1       synchronous clear of FIFO contents (pointers/count)
//  i_clr_err  in   1       clears sticky error flags
//  i_wr       in   1       write request
//  i_data     in   DATA_W  write data
//  i_rd       in   1       read request (pops the word currently on o_data)
//  o_data     out  DATA_W  head-of-FIFO data, first-word-fall-through
//  o_full     out  1       count == DEPTH
//  o_empty    out  1       count == 0
//  o_afull    out  1       count >= AF_LEVEL
//  o_aempty   out  1       count <= AE_LEVEL
//  o_count    out  CW      current occupancy 0..DEPTH
//  o_ovf      out  1       sticky: write attempted and rejected
//  o_udf      out  1       sticky: read attempted while empty
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (i_rst=1 at posedge): pointers=0, count=0, o_ovf=o_udf=0.
//   Outputs after reset: o_empty=1, o_aempty=1, o_full=0, o_afull=0 (AF_LEVEL>=1), o_count=0, o_data=0.
//   Memory array is not reset.
//  Pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits; they wrap DEPTH-1 -> 0 naturally.
//  Occupancy: a separate count register distinguishes full from empty, so all DEPTH entries are usable.
//  Accept rules, evaluated on current-cycle state:
//   rd_ok = i_rd & !o_empty
//   wr_ok = i_wr & (!o_full | rd_ok)
//   A write to a full FIFO is accepted only when a pop occurs in the same cycle.
//  At posedge:
//   if wr_ok: mem[wr_ptr] <= i_data; wr_ptr++
//   if rd_ok: rd_ptr++
//   count += wr_ok - rd_ok (simultaneous rd+wr leaves count unchanged)
//  Read path: o_data = o_empty ? 0 : mem[rd_ptr], combinational.
//   Latency: a word written into an empty FIFO appears on o_data the cycle after the write edge.
//   Empty + simultaneous rd+wr: the read is ignored (underflow), the write is stored, count becomes 1.
//  Flags: o_full, o_empty, o_afull, o_aempty are combinational decodes of the count register, so they update the cycle after the edge.
//  Errors:
//   o_ovf sets when i_wr & !wr_ok.
//   o_udf sets when i_rd & o_empty.
//   Both hold until i_clr_err or reset; if set and clear coincide, set wins.
//  Priority: i_rst > i_flush > normal operation.
//   i_flush: pointers and count = 0; a wr/rd in the same cycle is discarded; error flags are not changed.
//   Reset or flush mid-stream: all queued data is lost; o_empty=1 on the next cycle.
// TESTING (DATA_W=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1)
//  1 Reset, then write 0xA0..0xA7 in 8 cycles.
//    -> o_count 1..8; o_aempty drops at count 2; o_afull rises at 6; o_full=1 at 8.
//    -> Then read 8 cycles: o_data 0xA0..0xA7 in order, then o_empty=1, o_data=0.
//  2 Full FIFO, i_wr=1 alone with 0xBB.
//    -> Rejected; o_ovf=1 sticky; count stays 8.
//    -> Then i_wr+i_rd with 0xCC: accepted; count 8; 0xCC emerges as the 8th pop.
//  3 Empty FIFO, i_rd=1 with i_wr=1, 0x55.
//    -> o_udf=1; count=1; o_data=0x55 next cycle.
//    -> Pulse i_clr_err: o_ovf=o_udf=0.
//  4 Wrap: 20 cycles of continuous rd+wr at count 3, data = cycle index.
//    -> Count constant 3; output sequence equals input delayed by 3 pops; no flags.
//  5 Count 5, assert i_flush with i_wr=1.
//    -> Next cycle count=0, o_empty=1, write dropped.
//    -> Assert i_rst at count 4: same result and o_ovf/o_udf cleared.

Source files
------------

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with first-word-fall-through
// read data, an occupancy count, programmable almost-full/almost-empty flags,
// synchronous flush and sticky overflow/underflow debug flags.
// A separate count register tells full from empty, so all DEPTH entries hold data.
module param_sync_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_clr_err,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_afull,
    output logic              o_aempty,
    output logic [CW-1:0]     o_count,
    output logic              o_ovf,
    output logic              o_udf
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              ovf;
    logic              udf;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_ok;

    // Status decodes and accept rules from the current count; a full FIFO
    // still takes a write when a pop frees a slot in the same cycle.
    always_comb begin
        full  = (count == DEPTH_C);
        empty = (count == '0);
        rd_ok = i_rd & ~empty;
        wr_ok = i_wr & (~full | rd_ok);
    end

    // Storage array: written only on an accepted write, never reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && wr_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy: reset beats flush, flush drops any same-cycle traffic.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a new error in the clearing cycle keeps the flag set;
    // a flush leaves the flags exactly as they were.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (!i_flush) begin
            ovf <= (ovf & ~i_clr_err) | (i_wr & ~wr_ok);
            udf <= (udf & ~i_clr_err) | (i_rd & empty);
        end
    end

    // Head word falls through combinationally; zero whenever nothing is queued.
    always_comb begin
        o_data   = empty ? '0 : mem[rd_ptr];
        o_full   = full;
        o_empty  = empty;
        o_afull  = (count >= AF_C);
        o_aempty = (count <= AE_C);
        o_count  = count;
        o_ovf    = ovf;
        o_udf    = udf;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed scenarios followed by a randomised run, with
// every output compared each cycle against a queue-based reference FIFO.
module tb_param_sync_fifo;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 1;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic              i_clk;
    logic              i_rst;
    logic              i_flush;
    logic              i_clr_err;
    logic              i_wr;
    logic [DATA_W-1:0] i_data;
    logic              i_rd;
    logic [DATA_W-1:0] o_data;
    logic              o_full;
    logic              o_empty;
    logic              o_afull;
    logic              o_aempty;
    logic [CW-1:0]     o_count;
    logic              o_ovf;
    logic              o_udf;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queue of stored words plus the two sticky flags.
    logic [DATA_W-1:0] model_q [$];
    logic              model_ovf;
    logic              model_udf;

    param_sync_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_clr_err(i_clr_err),
        .i_wr     (i_wr),
        .i_data   (i_data),
        .i_rd     (i_rd),
        .o_data   (o_data),
        .o_full   (o_full),
        .o_empty  (o_empty),
        .o_afull  (o_afull),
        .o_aempty (o_aempty),
        .o_count  (o_count),
        .o_ovf    (o_ovf),
        .o_udf    (o_udf)
    );

    // Free-running 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkValue(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against what the queue model says it should be.
    task automatic checkOutput(input string tag);
        int n;
        n = model_q.size();
        checkValue({tag, ".count"},  DATA_W'(o_count), DATA_W'(n));
        checkValue({tag, ".data"},   o_data, (n == 0) ? '0 : model_q[0]);
        checkValue({tag, ".full"},   DATA_W'(o_full),   DATA_W'(n == DEPTH));
        checkValue({tag, ".empty"},  DATA_W'(o_empty),  DATA_W'(n == 0));
        checkValue({tag, ".afull"},  DATA_W'(o_afull),  DATA_W'(n >= AF_LEVEL));
        checkValue({tag, ".aempty"}, DATA_W'(o_aempty), DATA_W'(n <= AE_LEVEL));
        checkValue({tag, ".ovf"},    DATA_W'(o_ovf),    DATA_W'(model_ovf));
        checkValue({tag, ".udf"},    DATA_W'(o_udf),    DATA_W'(model_udf));
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, then
    // sample the DUT shortly after the edge and compare.
    task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                                 input logic [DATA_W-1:0] data, input logic flush,
                                 input logic clr, input logic rst);
        bit was_empty, pop, push;
        i_wr      = wr;
        i_rd      = rd;
        i_data    = data;
        i_flush   = flush;
        i_clr_err = clr;
        i_rst     = rst;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_udf = 1'b0;
        end else if (flush) begin
            model_q.delete();
        end else begin
            was_empty = (model_q.size() == 0);
            pop  = rd && !was_empty;
            push = wr && (model_q.size() < DEPTH || pop);
            if (clr) begin
                model_ovf = 1'b0;
                model_udf = 1'b0;
            end
            if (wr && !push)     model_ovf = 1'b1;
            if (rd && was_empty) model_udf = 1'b1;
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(data);
        end
        @(posedge i_clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_clr_err = 1'b0;
        i_wr = 1'b0; i_rd = 1'b0; i_data = '0;
        model_ovf = 1'b0; model_udf = 1'b0;
        #2;

        // Reset state
        applyStimulus("reset", 0, 0, 0, 0, 0, 1);
        applyStimulus("idle", 0, 0, 0, 0, 0, 0);

        // Fill with 0xA0..0xA7 then drain in order
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("t1_fill", 1, 0, DATA_W'(32'hA0 + i), 0, 0, 0);
        checkValue("t1_full_const", DATA_W'(o_full), 1);
        for (int i = 0; i < DEPTH; i++) begin
            checkValue("t1_order", o_data, DATA_W'(32'hA0 + i));
            applyStimulus("t1_drain", 0, 1, 0, 0, 0, 0);
        end
        checkValue("t1_empty_data", o_data, 0);

        // Overflow on a full FIFO, then write+read pass-through
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("t2_fill", 1, 0, DATA_W'(32'hB0 + i), 0, 0, 0);
        applyStimulus("t2_ovf", 1, 0, 32'hBB, 0, 0, 0);
        checkValue("t2_ovf_const", DATA_W'(o_ovf), 1);
        applyStimulus("t2_wr_rd_full", 1, 1, 32'hCC, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) checkValue("t2_cc_last", o_data, 32'hCC);
            applyStimulus("t2_drain", 0, 1, 0, 0, 0, 0);
        end

        // Read+write on empty: underflow flagged, write kept
        applyStimulus("t3_empty_rw", 1, 1, 32'h55, 0, 0, 0);
        checkValue("t3_head", o_data, 32'h55);
        checkValue("t3_udf_const", DATA_W'(o_udf), 1);
        applyStimulus("t3_clr", 0, 0, 0, 0, 1, 0);
        checkValue("t3_ovf_cleared", DATA_W'(o_ovf), 0);

        // Wrap-around: steady count of 3 under continuous read+write
        applyStimulus("t4_pre", 1, 0, 32'h1000, 0, 0, 0);
        applyStimulus("t4_pre", 1, 0, 32'h1001, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            applyStimulus("t4_wrap", 1, 1, DATA_W'(i), 0, 0, 0);
        checkValue("t4_count3", DATA_W'(o_count), 3);

        // Flush with a coincident write
        applyStimulus("t5_pre", 1, 0, 32'h2000, 0, 0, 0);
        applyStimulus("t5_pre", 1, 0, 32'h2001, 0, 0, 0);
        applyStimulus("t5_flush", 1, 0, 32'hDEAD, 1, 0, 0);
        checkValue("t5_flush_empty", DATA_W'(o_empty), 1);

        // Reset mid-stream with both error flags set
        applyStimulus("t5_udf", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("t5_fill", 1, 0, DATA_W'(32'h3000 + i), 0, 0, 0);
        applyStimulus("t5_ovf", 1, 0, 32'h3FFF, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus("t5_to4", 0, 1, 0, 0, 0, 0);
        applyStimulus("t5_rst", 1, 1, 32'h4444, 0, 0, 1);
        checkValue("t5_rst_udf", DATA_W'(o_udf), 0);

        // Randomised traffic with occasional flush, clear and reset
        for (int i = 0; i < 400; i++) begin
            logic wr, rd, fl, cl, rs;
            wr = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 50);
            fl = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 79) == 0);
            applyStimulus("rand", wr, rd, DATA_W'($urandom), fl, cl, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
